muldiv_sched: RTL and testbench

Multi-cycle sequencer for the RV32M operations in the EX stage. It drives the clock enables and operand selection of the pipelined multiplier IPs and contains an iterative radix-2 divider. It stalls the pipeline until the result is final, then returns a single 32-bit result with a one-cycle valid pulse. It sits beside the ALU and replaces the ALU-local multiply stall logic.

---
 rtl/muldiv_sched_if.sv | 44 ++++
 rtl/muldiv_sched.sv | 253 +++++++++++++++++++++++++
 tb/tb_muldiv_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// -----------------------------------------------------------------------------
// muldiv_sched_if
// Handshake and bus signals between the EX stage / multiplier IPs and the
// RV32M sequencer muldiv_sched.
//
//   load_hazard  pipeline load-use freeze
//   op_valid     EX stage holds an M-extension instruction
//   md_op[2:0]   funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU)
//   op_a, op_b   source operands
//   mul_p[63:0]  product from the selected multiplier IP
//   mul_ce       multiplier IP clock enable
//   mul_sel[1:0] IP select: 0 unsigned, 1 signed, 2 signed x unsigned
//   md_stall     hold IF/ID/EX
//   res          result, valid only with res_valid
//   res_valid    one-cycle completion pulse
//   busy         sequencer not idle
//
// slave  : the sequencer side
// master : the pipeline / multiplier side
// -----------------------------------------------------------------------------
interface muldiv_sched_if;
    logic        load_hazard;
    logic        op_valid;
    logic [2:0]  md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] mul_p;
    logic        mul_ce;
    logic [1:0]  mul_sel;
    logic        md_stall;
    logic [31:0] res;
    logic        res_valid;
    logic        busy;

    modport slave (
        input  load_hazard, op_valid, md_op, op_a, op_b, mul_p,
        output mul_ce, mul_sel, md_stall, res, res_valid, busy
    );

    modport master (
        output load_hazard, op_valid, md_op, op_a, op_b, mul_p,
        input  mul_ce, mul_sel, md_stall, res, res_valid, busy
    );
endinterface

// File: rtl/muldiv_sched.sv
// -----------------------------------------------------------------------------
// muldiv_sched
// Multi-cycle sequencer for RV32M in the EX stage. Drives the clock enable and
// select of the pipelined multiplier IPs, runs an iterative restoring radix-2
// divider, stalls the pipeline until the result is final and then returns the
// 32-bit result with a one-cycle res_valid pulse.
//
// Parameters:
//   MUL_LATENCY  cycles from the CE-asserted accept edge until mul_p is valid (1..7)
//
// Ports:
//   CLK   system clock
//   nrst  synchronous active-low reset
//   bus   muldiv_sched_if.slave (handshake, operands, multiplier IP, result)
//
// Optional feature:
//   MULDIV_REUSE_EN  when defined, the last completed normal division is kept
//                    and an identical following divide returns it in one stall
//                    cycle.
// -----------------------------------------------------------------------------
module muldiv_sched #(
    parameter int MUL_LATENCY = 1
) (
    input  logic          CLK,
    input  logic          nrst,
    muldiv_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DONE} state_t;

    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LATENCY - 1);

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [63:0] rq_reg, rq_next;          // remainder:quotient
    logic [31:0] divisor_reg, divisor_next;
    logic [2:0]  op_reg, op_next;
    logic        q_neg_reg, q_neg_next;
    logic        r_neg_reg, r_neg_next;

    // combinational output values before reset gating
    logic        ce_c, stall_c, valid_c;
    logic [31:0] res_c;
    logic [1:0]  sel_c;

    function automatic logic [1:0] sel_decode(input logic [2:0] op);
        case (op)
            3'd1:    return 2'd1;   // MULH   : signed x signed
            3'd2:    return 2'd2;   // MULHSU : signed x unsigned
            default: return 2'd0;   // MUL, MULHU and divides: unsigned IP
        endcase
    endfunction

    // ---------------- accept-cycle operand decode ----------------
    logic        accept;
    logic        is_signed_div;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic        div_zero, div_ovf;
    logic        reuse_hit;

    assign accept        = bus.op_valid & ~bus.load_hazard;
    assign is_signed_div = ~bus.md_op[0];   // DIV/REM signed, DIVU/REMU unsigned
    assign a_neg         = is_signed_div & bus.op_a[31];
    assign b_neg         = is_signed_div & bus.op_b[31];
    assign abs_a         = a_neg ? (32'd0 - bus.op_a) : bus.op_a;
    assign abs_b         = b_neg ? (32'd0 - bus.op_b) : bus.op_b;
    assign div_zero      = (bus.op_b == 32'd0);
    assign div_ovf       = is_signed_div && (bus.op_a == 32'h8000_0000) &&
                           (bus.op_b == 32'hFFFF_FFFF);

    // ---------------- one restoring division step ----------------
    // The 33-bit partial can exceed 2^32 only when it is already >= divisor,
    // so a borrow out of bit 33 is the "restore" decision.
    logic [32:0] partial;
    logic [33:0] diff;
    logic [63:0] div_step;

    assign partial  = {rq_reg[63:32], rq_reg[31]};
    assign diff     = {1'b0, partial} - {2'b00, divisor_reg};
    assign div_step = diff[33] ? {partial[31:0], rq_reg[30:0], 1'b0}
                               : {diff[31:0],    rq_reg[30:0], 1'b1};

    // sign-corrected divider results
    logic [31:0] quot_c, rem_c;
    assign quot_c = q_neg_reg ? (32'd0 - rq_reg[31:0])  : rq_reg[31:0];
    assign rem_c  = r_neg_reg ? (32'd0 - rq_reg[63:32]) : rq_reg[63:32];

    // ---------------- optional result reuse ----------------
`ifdef MULDIV_REUSE_EN
    logic        entry_valid_reg;
    logic        entry_signed_reg;
    logic [31:0] entry_a_reg, entry_b_reg, entry_quot_reg, entry_rem_reg;
    logic [31:0] a_reg, b_reg;
    logic        ran_div_reg;   // current op went through DIV_RUN

    assign reuse_hit = entry_valid_reg &&
                       (bus.op_a == entry_a_reg) &&
                       (bus.op_b == entry_b_reg) &&
                       (is_signed_div == entry_signed_reg);

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            entry_valid_reg  <= 1'b0;
            entry_signed_reg <= 1'b0;
            entry_a_reg      <= '0;
            entry_b_reg      <= '0;
            entry_quot_reg   <= '0;
            entry_rem_reg    <= '0;
            a_reg            <= '0;
            b_reg            <= '0;
            ran_div_reg      <= 1'b0;
        end else begin
            if (state_reg == IDLE && accept) begin
                a_reg       <= bus.op_a;
                b_reg       <= bus.op_b;
                ran_div_reg <= bus.md_op[2] && !div_zero && !div_ovf && !reuse_hit;
            end
            if (state_reg == DONE && !bus.load_hazard && ran_div_reg) begin
                entry_valid_reg  <= 1'b1;
                entry_signed_reg <= ~op_reg[0];
                entry_a_reg      <= a_reg;
                entry_b_reg      <= b_reg;
                entry_quot_reg   <= quot_c;
                entry_rem_reg    <= rem_c;
            end
        end
    end
`else
    assign reuse_hit = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rq_reg      <= '0;
            divisor_reg <= '0;
            op_reg      <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rq_reg      <= rq_next;
            divisor_reg <= divisor_next;
            op_reg      <= op_next;
            q_neg_reg   <= q_neg_next;
            r_neg_reg   <= r_neg_next;
        end
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rq_next      = rq_reg;
        divisor_next = divisor_reg;
        op_next      = op_reg;
        q_neg_next   = q_neg_reg;
        r_neg_next   = r_neg_reg;
        ce_c         = 1'b0;
        stall_c      = 1'b0;
        valid_c      = 1'b0;
        res_c        = 32'd0;
        sel_c        = sel_decode(op_reg);

        case (state_reg)
            IDLE: begin
                sel_c   = sel_decode(bus.md_op);
                stall_c = accept;
                if (accept) begin
                    op_next = bus.md_op;
                    if (!bus.md_op[2]) begin
                        ce_c       = 1'b1;
                        cnt_next   = MUL_CNT_INIT;
                        state_next = (MUL_CNT_INIT == 5'd0) ? DONE : MUL_WAIT;
                    end else if (div_zero) begin
                        rq_next    = {bus.op_a, 32'hFFFF_FFFF};
                        q_neg_next = 1'b0;
                        r_neg_next = 1'b0;
                        state_next = DONE;
                    end else if (div_ovf) begin
                        rq_next    = {32'd0, 32'h8000_0000};
                        q_neg_next = 1'b0;
                        r_neg_next = 1'b0;
                        state_next = DONE;
`ifdef MULDIV_REUSE_EN
                    end else if (reuse_hit) begin
                        rq_next    = {entry_rem_reg, entry_quot_reg};
                        q_neg_next = 1'b0;
                        r_neg_next = 1'b0;
                        state_next = DONE;
`endif
                    end else begin
                        rq_next      = {32'd0, abs_a};
                        divisor_next = abs_b;
                        q_neg_next   = a_neg ^ b_neg;
                        r_neg_next   = a_neg;
                        cnt_next     = 5'd31;
                        state_next   = DIV_RUN;
                    end
                end
            end

            MUL_WAIT: begin
                stall_c = 1'b1;
                if (!bus.load_hazard) begin
                    // the accept edge was the first CE edge; leave after the
                    // remaining MUL_LATENCY-1 CE edges
                    ce_c     = 1'b1;
                    cnt_next = cnt_reg - 5'd1;
                    if (cnt_reg == 5'd1)
                        state_next = DONE;
                end
            end

            DIV_RUN: begin
                stall_c = 1'b1;
                if (!bus.load_hazard) begin
                    rq_next = div_step;
                    if (cnt_reg == 5'd0)
                        state_next = DONE;
                    else
                        cnt_next = cnt_reg - 5'd1;
                end
            end

            DONE: begin
                if (op_reg[2])
                    res_c = op_reg[1] ? rem_c : quot_c;
                else
                    res_c = (op_reg[1:0] == 2'd0) ? bus.mul_p[31:0] : bus.mul_p[63:32];
                if (!bus.load_hazard) begin
                    valid_c    = 1'b1;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // all outputs are quiet while reset is asserted
    assign bus.mul_ce    = nrst & ce_c;
    assign bus.md_stall  = nrst & stall_c;
    assign bus.res_valid = nrst & valid_c;
    assign bus.res       = nrst ? res_c : 32'd0;
    assign bus.mul_sel   = sel_c;
    assign bus.busy      = nrst & (state_reg != IDLE);

endmodule

// File: tb/tb_muldiv_sched.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sched
// Directed bench for muldiv_sched. Two instances (MUL_LATENCY 1 and 3) share
// the operand/hazard/reset stimulus; op_valid is steered to one at a time.
// -----------------------------------------------------------------------------
module tb_muldiv_sched;

`ifdef MULDIV_REUSE_EN
    localparam int RU = 1;
`else
    localparam int RU = 0;
`endif
    // result cycle / stall count of a divide that may hit the reuse entry
    localparam int HC = (RU != 0) ? 2 : 34;
    localparam int HS = (RU != 0) ? 1 : 33;

    logic        CLK = 1'b0;
    logic        nrst;
    logic        load_hazard;
    logic        op_valid;
    logic [2:0]  md_op;
    logic [31:0] op_a, op_b;
    logic [63:0] mul_p;
    logic        use3_r;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    muldiv_sched_if if1();
    muldiv_sched_if if3();

    assign if1.load_hazard = load_hazard;
    assign if1.op_valid    = op_valid & ~use3_r;
    assign if1.md_op       = md_op;
    assign if1.op_a        = op_a;
    assign if1.op_b        = op_b;
    assign if1.mul_p       = mul_p;

    assign if3.load_hazard = load_hazard;
    assign if3.op_valid    = op_valid & use3_r;
    assign if3.md_op       = md_op;
    assign if3.op_a        = op_a;
    assign if3.op_b        = op_b;
    assign if3.mul_p       = mul_p;

    muldiv_sched #(.MUL_LATENCY(1)) dut1 (.CLK(CLK), .nrst(nrst), .bus(if1));
    muldiv_sched #(.MUL_LATENCY(3)) dut3 (.CLK(CLK), .nrst(nrst), .bus(if3));

    // observed outputs of the currently selected instance
    logic        o_stall, o_ce, o_valid, o_busy;
    logic [1:0]  o_sel;
    logic [31:0] o_res;
    assign o_stall = use3_r ? if3.md_stall  : if1.md_stall;
    assign o_ce    = use3_r ? if3.mul_ce    : if1.mul_ce;
    assign o_valid = use3_r ? if3.res_valid : if1.res_valid;
    assign o_busy  = use3_r ? if3.busy      : if1.busy;
    assign o_sel   = use3_r ? if3.mul_sel   : if1.mul_sel;
    assign o_res   = use3_r ? if3.res       : if1.res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op and follow it to res_valid. Cycle 1 is the first cycle
    // op_valid is presented; hazard is high in cycles [hz_start, hz_start+hz_len).
    task automatic run_op(input string tag, input bit use3, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] p, input logic [31:0] exp_res,
                          input int exp_cyc, input int exp_stall, input int exp_ce,
                          input int exp_sel, input int hz_start, input int hz_len);
        int cyc = 0, stalls = 0, ces = 0;
        logic got = 1'b0;
        logic [31:0] r = '0;
        use3_r   = use3;
        md_op    = op;
        op_a     = a;
        op_b     = b;
        mul_p    = p;
        op_valid = 1'b1;
        for (int i = 1; i <= 100 && !got; i++) begin
            load_hazard = (i >= hz_start) && (i < hz_start + hz_len);
            #1;
            if (o_stall) stalls++;
            if (o_ce) begin
                ces++;
                if (exp_sel >= 0) chk({tag, ".sel"}, 32'(o_sel), 32'(exp_sel));
            end
            if (o_valid) begin
                got = 1'b1;
                cyc = i;
                r   = o_res;
            end
            @(negedge CLK);
        end
        op_valid    = 1'b0;
        load_hazard = 1'b0;
        chk({tag, ".done"},   32'(got),    32'd1);
        chk({tag, ".res"},    r,           exp_res);
        chk({tag, ".cycle"},  32'(cyc),    32'(exp_cyc));
        chk({tag, ".stalls"}, 32'(stalls), 32'(exp_stall));
        chk({tag, ".ce"},     32'(ces),    32'(exp_ce));
        #1;
        chk({tag, ".pulse"},  32'(o_valid), 32'd0);
        chk({tag, ".idle"},   32'(o_busy),  32'd0);
        $display("%-10s op=%0d a=%h b=%h res=%h cycle=%0d stalls=%0d ce=%0d",
                 tag, op, a, b, r, cyc, stalls, ces);
        @(negedge CLK);
    endtask

    initial begin
        int seen;
        nrst        = 1'b0;
        load_hazard = 1'b0;
        op_valid    = 1'b1;   // outputs must stay quiet during reset regardless
        md_op       = 3'd0;
        op_a        = 32'd0;
        op_b        = 32'd0;
        mul_p       = 64'd0;
        use3_r      = 1'b0;

        repeat (3) @(negedge CLK);
        #1;
        chk("rst.stall", 32'(if1.md_stall),  32'd0);
        chk("rst.ce",    32'(if1.mul_ce),    32'd0);
        chk("rst.valid", 32'(if1.res_valid), 32'd0);
        chk("rst.busy",  32'(if1.busy),      32'd0);
        chk("rst.res",   if1.res,            32'd0);
        op_valid = 1'b0;
        nrst     = 1'b1;
        @(negedge CLK);
        #1;
        chk("rst.busy2", 32'(if1.busy), 32'd0);
        @(negedge CLK);

        // multiplies
        run_op("mul",      0, 3'd0, 32'd7, 32'd6, 64'd42, 32'd42, 2, 1, 1, 0, 0, 0);
        run_op("mul_l3",   1, 3'd0, 32'd7, 32'd6, 64'd42, 32'd42, 4, 3, 3, 0, 0, 0);
        run_op("mulh",     0, 3'd1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000,
               32'h4000_0000, 2, 1, 1, 1, 0, 0);
        run_op("mulhu",    0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
               32'hFFFF_FFFE, 2, 1, 1, 0, 0, 0);
        run_op("mulhsu_hz",0, 3'd2, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE,
               32'hFFFF_FFFF, 3, 1, 1, 2, 1, 1);
        run_op("mul_hzdn", 0, 3'd0, 32'd3, 32'd5, 64'd15, 32'd15, 4, 1, 1, 0, 2, 2);

        // normal divides
        run_op("div",      0, 3'd4, 32'hFFFF_FFF9, 32'd2, 64'd0, 32'hFFFF_FFFD, 34, 33, 0, -1, 0, 0);
        run_op("rem",      0, 3'd6, 32'hFFFF_FFF9, 32'd2, 64'd0, 32'hFFFF_FFFF, HC, HS, 0, -1, 0, 0);
        run_op("divu",     0, 3'd5, 32'd100, 32'd7, 64'd0, 32'd14, 34, 33, 0, -1, 0, 0);
        run_op("remu",     0, 3'd7, 32'd100, 32'd7, 64'd0, 32'd2, HC, HS, 0, -1, 0, 0);

        // special cases
        run_op("divu_z",   0, 3'd5, 32'd5, 32'd0, 64'd0, 32'hFFFF_FFFF, 2, 1, 0, -1, 0, 0);
        run_op("remu_z",   0, 3'd7, 32'd5, 32'd0, 64'd0, 32'd5, 2, 1, 0, -1, 0, 0);
        run_op("div_ovf",  0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 32'h8000_0000, 2, 1, 0, -1, 0, 0);
        run_op("rem_ovf",  0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 32'd0, 2, 1, 0, -1, 0, 0);
        run_op("div_z",    0, 3'd4, 32'hFFFF_FFFB, 32'd0, 64'd0, 32'hFFFF_FFFF, 2, 1, 0, -1, 0, 0);
        run_op("rem_z",    0, 3'd6, 32'hFFFF_FFFB, 32'd0, 64'd0, 32'hFFFF_FFFB, 2, 1, 0, -1, 0, 0);

        // negative divisor, then a hazard in the middle of DIV_RUN
        run_op("div_nb",   0, 3'd4, 32'd7, 32'hFFFF_FFFE, 64'd0, 32'hFFFF_FFFD, 34, 33, 0, -1, 0, 0);
        run_op("rem_nb",   0, 3'd6, 32'd7, 32'hFFFF_FFFE, 64'd0, 32'd1, HC, HS, 0, -1, 0, 0);
        run_op("div_hz",   0, 3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 64'd0, 32'hD555_5556, 37, 36, 0, -1, 10, 3);

        // reuse pair
        run_op("div_100",  0, 3'd4, 32'd100, 32'd7, 64'd0, 32'd14, 34, 33, 0, -1, 0, 0);
        run_op("rem_100",  0, 3'd6, 32'd100, 32'd7, 64'd0, 32'd2, HC, HS, 0, -1, 0, 0);

        // reset at DIV_RUN step 10
        use3_r   = 1'b0;
        md_op    = 3'd5;
        op_a     = 32'd1000;
        op_b     = 32'd3;
        op_valid = 1'b1;
        @(negedge CLK);
        op_valid = 1'b0;
        repeat (10) @(negedge CLK);
        #1;
        chk("rstmid.busy_before", 32'(if1.busy), 32'd1);
        nrst = 1'b0;
        #1;
        chk("rstmid.stall", 32'(if1.md_stall), 32'd0);
        chk("rstmid.busy",  32'(if1.busy),     32'd0);
        @(negedge CLK);
        nrst = 1'b1;
        #1;
        chk("rstmid.idle", 32'(if1.busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #1;
            if (if1.res_valid || if1.busy) seen++;
        end
        chk("rstmid.quiet", 32'(seen), 32'd0);
        $display("rstmid     reset at DIV_RUN step 10, activity after reset=%0d", seen);
        @(negedge CLK);

        // stored entry must be gone after reset
        run_op("div_post", 0, 3'd4, 32'd100, 32'd7, 64'd0, 32'd14, 34, 33, 0, -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
